// File: rtl/bus_grant_sequencer.sv
// Round-robin bus arbiter: grants one source at a time onto the shared CPU bus,
// with bounded tenure (MAX_HOLD), lock override and a base-address flag for source 0.
module bus_grant_sequencer #(
  parameter int REGISTERS = 23,
  parameter int MAX_HOLD  = 4,
  parameter int IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [REGISTERS-1:0] req,
  input  logic                 lock,
  input  logic                 ba_mode,
  output logic [REGISTERS-1:0] registerSelect,
  output logic                 BAOut,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 bus_busy,
  output logic [3:0]           tenure
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_OWN    = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0]           state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [REGISTERS-1:0] sel_q, sel_d;
  logic                 ba_q, ba_d;
  logic [3:0]           ten_q, ten_d;

  logic [REGISTERS-1:0] others;
  logic [IDX_W-1:0]     next_k;
  logic [IDX_W-1:0]     idle_win;
  logic [IDX_W-1:0]     hand_win;
  logic                 yield;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(REGISTERS - 1)) ? '0 : k + 1'b1;
  endfunction

  function automatic logic [REGISTERS-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [REGISTERS-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // First set bit at or above start, wrapping past the top source back to 0.
  function automatic logic [IDX_W-1:0] rr_scan(input logic [REGISTERS-1:0] r,
                                               input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] win;
    logic             found;
    pos   = start;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (!found && r[pos]) begin
        found = 1'b1;
        win   = pos;
      end
      pos = wrap_inc(pos);
    end
    return win;
  endfunction

  assign others   = req & ~onehot(idx_q);
  assign next_k   = wrap_inc(idx_q);
  assign idle_win = rr_scan(req, rr_q);
  assign hand_win = rr_scan(others, next_k);
  assign yield    = !req[idx_q] || (!lock && (ten_q == HOLD_MAX) && (|others));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    ba_d    = ba_q;
    ten_d   = ten_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_OWN;
          idx_d   = idle_win;
          sel_d   = onehot(idle_win);
          ba_d    = (idle_win == '0) && ba_mode;
          ten_d   = 4'd1;
        end
      end
      S_OWN: begin
        if (yield) begin
          rr_d = next_k;
          // Hand-off happens on the same edge so the bus never idles between owners.
          if (|others) begin
            idx_d = hand_win;
            sel_d = onehot(hand_win);
            ba_d  = (hand_win == '0) && ba_mode;
            ten_d = 4'd1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            sel_d   = '0;
            ba_d    = 1'b0;
            ten_d   = 4'd0;
          end
        end else if (ten_q != HOLD_MAX) begin
          ten_d = ten_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        sel_d   = '0;
        ba_d    = 1'b0;
        ten_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      ba_q    <= 1'b0;
      ten_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      ba_q    <= ba_d;
      ten_q   <= ten_d;
    end
  end

  assign registerSelect = sel_q;
  assign BAOut          = ba_q;
  assign grant_idx      = idx_q;
  assign bus_busy       = (state_q == S_OWN);
  assign tenure         = ten_q;

endmodule
